// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and controller-side signal bundle for sdram_port_arbiter.
// slave = arbiter view; master = surrounding requesters and SDRAM controller.
interface sdram_port_arbiter_if #(
  parameter int NPORTS  = 4,
  parameter int DATA_W  = 128,
  parameter int ADRS_W  = 25,
  parameter int BURST_W = 4
);
  localparam int BE_W = DATA_W / 8;

  logic [NPORTS-1:0]         req_write;
  logic [NPORTS-1:0]         req_read;
  logic [NPORTS*ADRS_W-1:0]  req_adrs;
  logic [NPORTS*DATA_W-1:0]  req_din;
  logic [NPORTS*BE_W-1:0]    req_enable;
  logic [NPORTS*BURST_W-1:0] req_burst;
  logic [NPORTS-1:0]         req_busy;
  logic [NPORTS-1:0]         req_ack;
  logic [DATA_W-1:0]         req_dout;
  logic                      sdram_write;
  logic                      sdram_read;
  logic [ADRS_W-1:0]         sdram_adrs;
  logic [DATA_W-1:0]         sdram_din;
  logic [BE_W-1:0]           sdram_enable;
  logic [BURST_W-1:0]        sdram_burst;
  logic [DATA_W-1:0]         sdram_dout;
  logic                      sdram_ack;

  modport slave (
    input  req_write, req_read, req_adrs, req_din, req_enable, req_burst,
    input  sdram_dout, sdram_ack,
    output req_busy, req_ack, req_dout,
    output sdram_write, sdram_read, sdram_adrs, sdram_din, sdram_enable, sdram_burst
  );

  modport master (
    output req_write, req_read, req_adrs, req_din, req_enable, req_burst,
    output sdram_dout, sdram_ack,
    input  req_busy, req_ack, req_dout,
    input  sdram_write, sdram_read, sdram_adrs, sdram_din, sdram_enable, sdram_burst
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// N-port round-robin arbiter serialising per-port command slots onto one SDRAM controller port.
// Define SDRAM_ARB_PRIO0_EN to make port 0 strict priority over a round-robin of ports 1..N-1.
module sdram_port_arbiter #(
  parameter int NPORTS  = 4,
  parameter int DATA_W  = 128,
  parameter int ADRS_W  = 25,
  parameter int BURST_W = 4
) (
  input  logic                m_clock,
  input  logic                p_reset,
  sdram_port_arbiter_if.slave bus
);
  localparam int          BE_W  = DATA_W / 8;
  localparam int          IDX_W = $clog2(NPORTS);
  localparam int unsigned NP    = NPORTS;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e             state_q;
  logic [NPORTS-1:0]  pend_q;
  logic [NPORTS-1:0]  wr_q;
  logic [ADRS_W-1:0]  adrs_q  [NPORTS];
  logic [DATA_W-1:0]  din_q   [NPORTS];
  logic [BE_W-1:0]    en_q    [NPORTS];
  logic [BURST_W-1:0] burst_q [NPORTS];
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_q;

  logic               sdram_write_q;
  logic               sdram_read_q;
  logic [ADRS_W-1:0]  sdram_adrs_q;
  logic [DATA_W-1:0]  sdram_din_q;
  logic [BE_W-1:0]    sdram_enable_q;
  logic [BURST_W-1:0] sdram_burst_q;
  logic [NPORTS-1:0]  req_ack_q;
  logic [DATA_W-1:0]  req_dout_q;

  logic               found_d;
  logic [IDX_W-1:0]   pick_d;
  logic               rr_upd_d;
  int unsigned        idx;

  // Grant scan over registered slot state only; a slot captured this cycle waits a cycle.
  always_comb begin
    found_d  = 1'b0;
    pick_d   = '0;
    rr_upd_d = 1'b1;
    idx      = 0;
`ifdef SDRAM_ARB_PRIO0_EN
    if (pend_q[0]) begin
      found_d  = 1'b1;
      rr_upd_d = 1'b0;
    end else begin
      for (int unsigned k = 1; k <= NP; k++) begin
        idx = (32'(rr_q) + k) % NP;
        if (!found_d && idx != 0 && pend_q[IDX_W'(idx)]) begin
          found_d = 1'b1;
          pick_d  = IDX_W'(idx);
        end
      end
    end
`else
    for (int unsigned k = 1; k <= NP; k++) begin
      idx = (32'(rr_q) + k) % NP;
      if (!found_d && pend_q[IDX_W'(idx)]) begin
        found_d = 1'b1;
        pick_d  = IDX_W'(idx);
      end
    end
`endif
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q        <= S_IDLE;
      pend_q         <= '0;
      wr_q           <= '0;
      for (int unsigned i = 0; i < NP; i++) begin
        adrs_q[i]  <= '0;
        din_q[i]   <= '0;
        en_q[i]    <= '0;
        burst_q[i] <= '0;
      end
      grant_q        <= '0;
      rr_q           <= IDX_W'(NP - 1);
      sdram_write_q  <= 1'b0;
      sdram_read_q   <= 1'b0;
      sdram_adrs_q   <= '0;
      sdram_din_q    <= '0;
      sdram_enable_q <= '0;
      sdram_burst_q  <= '0;
      req_ack_q      <= '0;
      req_dout_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < NP; i++) begin
        if (!pend_q[i] && (bus.req_write[i] || bus.req_read[i])) begin
          pend_q[i]  <= 1'b1;
          wr_q[i]    <= bus.req_write[i];
          adrs_q[i]  <= bus.req_adrs[i*ADRS_W +: ADRS_W];
          din_q[i]   <= bus.req_din[i*DATA_W +: DATA_W];
          en_q[i]    <= bus.req_enable[i*BE_W +: BE_W];
          burst_q[i] <= bus.req_burst[i*BURST_W +: BURST_W];
        end
      end

      unique case (state_q)
        S_IDLE: begin
          if (found_d) begin
            grant_q        <= pick_d;
            if (rr_upd_d) rr_q <= pick_d;
            sdram_write_q  <= wr_q[pick_d];
            sdram_read_q   <= !wr_q[pick_d];
            sdram_adrs_q   <= adrs_q[pick_d];
            sdram_din_q    <= din_q[pick_d];
            sdram_enable_q <= en_q[pick_d];
            sdram_burst_q  <= burst_q[pick_d];
            state_q        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          sdram_write_q <= 1'b0;
          sdram_read_q  <= 1'b0;
          state_q       <= S_WAIT;
        end
        S_WAIT: begin
          // Slot frees on the ack edge so busy drops and a new capture is possible in DONE.
          if (bus.sdram_ack) begin
            if (!wr_q[grant_q]) req_dout_q <= bus.sdram_dout;
            req_ack_q[grant_q] <= 1'b1;
            pend_q[grant_q]    <= 1'b0;
            state_q            <= S_DONE;
          end
        end
        S_DONE: begin
          req_ack_q <= '0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_busy     = pend_q;
  assign bus.req_ack      = req_ack_q;
  assign bus.req_dout     = req_dout_q;
  assign bus.sdram_write  = sdram_write_q;
  assign bus.sdram_read   = sdram_read_q;
  assign bus.sdram_adrs   = sdram_adrs_q;
  assign bus.sdram_din    = sdram_din_q;
  assign bus.sdram_enable = sdram_enable_q;
  assign bus.sdram_burst  = sdram_burst_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: single-transaction vector table plus multi-cycle sequences,
// with controller commands compared against a queue of expected commands.
module tb_sdram_port_arbiter;
  localparam int NP = 4;
  localparam int DW = 128;
  localparam int AW = 25;
  localparam int BW = 4;
  localparam int EW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NPORTS(NP), .DATA_W(DW), .ADRS_W(AW), .BURST_W(BW)) bus ();

  sdram_port_arbiter #(.NPORTS(NP), .DATA_W(DW), .ADRS_W(AW), .BURST_W(BW)) dut (
    .m_clock (clk),
    .p_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] adrs;
    logic [DW-1:0] din;
    logic [EW-1:0] en;
    logic [BW-1:0] burst;
  } cmd_t;

  typedef struct {
    int            port;
    logic          wr;
    logic          rd;
    logic [AW-1:0] adrs;
    logic [DW-1:0] din;
    logic [EW-1:0] en;
    logic [BW-1:0] burst;
    logic [DW-1:0] rdata;
    logic          exp_wr;
    logic [DW-1:0] exp_dout;
  } vec_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int   total    = 0;
  int   bad      = 0;
  int   cmd_seen = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.sdram_write || bus.sdram_read)) begin
      cmd_seen++;
      check("cmd_expected", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("cmd_write",  DW'(bus.sdram_write),  DW'(mon_e.wr));
        check("cmd_read",   DW'(bus.sdram_read),   DW'(!mon_e.wr));
        check("cmd_adrs",   DW'(bus.sdram_adrs),   DW'(mon_e.adrs));
        check("cmd_din",    bus.sdram_din,         mon_e.din);
        check("cmd_enable", DW'(bus.sdram_enable), DW'(mon_e.en));
        check("cmd_burst",  DW'(bus.sdram_burst),  DW'(mon_e.burst));
      end
    end
  end

  task automatic load(input int p, input logic wr, input logic rd, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic [EW-1:0] e, input logic [BW-1:0] b);
    bus.req_write[p]              = wr;
    bus.req_read[p]               = rd;
    bus.req_adrs[p*AW +: AW]      = a;
    bus.req_din[p*DW +: DW]       = d;
    bus.req_enable[p*EW +: EW]    = e;
    bus.req_burst[p*BW +: BW]     = b;
  endtask

  task automatic push(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [EW-1:0] e, input logic [BW-1:0] b);
    cmd_t c;
    c.wr = wr; c.adrs = a; c.din = d; c.en = e; c.burst = b;
    exp_q.push_back(c);
  endtask

  task automatic pulse();
    @(posedge clk); #1;
    bus.req_write = '0;
    bus.req_read  = '0;
  endtask

  task automatic wait_cmd(output int n);
    n = 0;
    @(negedge clk);
    while (!(bus.sdram_write || bus.sdram_read) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL cmd_timeout: got no controller command within %0d cycles", n);
    end
  endtask

  task automatic do_ack(input logic [DW-1:0] d);
    bus.sdram_dout = d;
    bus.sdram_ack  = 1'b1;
    @(posedge clk); #1;
    bus.sdram_ack  = 1'b0;
    bus.sdram_dout = '0;
  endtask

  task automatic serve(input logic [DW-1:0] d, input int delay, output int n);
    wait_cmd(n);
    repeat (delay) begin
      @(posedge clk); #1;
    end
    do_ack(d);
  endtask

  task automatic check_done(input int p, input logic [DW-1:0] dout, input string tag);
    logic [NP-1:0] oh;
    oh    = '0;
    oh[p] = 1'b1;
    @(negedge clk);
    check({tag, "_ack"},  DW'(bus.req_ack), DW'(oh));
    check({tag, "_dout"}, bus.req_dout, dout);
    check({tag, "_busy_clear"}, DW'(bus.req_busy[p]), DW'(0));
    @(posedge clk); #1;
    bus.req_write = '0;
    bus.req_read  = '0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, DW'(bus.req_ack), '0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy_ack"},  DW'({bus.req_busy, bus.req_ack}), '0);
    check({tag, "_req_dout"},  bus.req_dout, '0);
    check({tag, "_sdram_ctl"}, DW'({bus.sdram_write, bus.sdram_read, bus.sdram_adrs,
                                    bus.sdram_enable, bus.sdram_burst}), '0);
    check({tag, "_sdram_din"}, bus.sdram_din, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vt [5];
    int            n;
    int            n0;
    int            ord [4];
    logic [NP-1:0] acc;
    cmd_t          c0b;

    vt[0] = '{2, 1'b0, 1'b1, 25'h0001234, 128'h0, 16'h0000, 4'h1,
              {16{8'hA5}}, 1'b0, {16{8'hA5}}};
    vt[1] = '{3, 1'b1, 1'b0, 25'h00ABCDE, {4{32'h11223344}}, 16'h000F, 4'h4,
              {8{16'hDEAD}}, 1'b1, {16{8'hA5}}};
    vt[2] = '{1, 1'b1, 1'b1, 25'h1FFFFFF, {32{4'hF}}, 16'hFFFF, 4'hF,
              {8{16'hBEEF}}, 1'b1, {16{8'hA5}}};
    vt[3] = '{0, 1'b0, 1'b1, 25'h0000000, {4{32'h0F0F0F0F}}, 16'h1234, 4'h0,
              128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210};
    vt[4] = '{1, 1'b0, 1'b1, 25'h0155555, 128'h1, 16'h8001, 4'h7,
              {16{8'h5A}}, 1'b0, {16{8'h5A}}};

    bus.req_write  = '0;
    bus.req_read   = '0;
    bus.req_adrs   = '0;
    bus.req_din    = '0;
    bus.req_enable = '0;
    bus.req_burst  = '0;
    bus.sdram_dout = '0;
    bus.sdram_ack  = 1'b0;

    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Single transactions, each on an idle arbiter
    for (int i = 0; i < 5; i++) begin
      load(vt[i].port, vt[i].wr, vt[i].rd, vt[i].adrs, vt[i].din, vt[i].en, vt[i].burst);
      push(vt[i].exp_wr, vt[i].adrs, vt[i].din, vt[i].en, vt[i].burst);
      pulse();
      serve(vt[i].rdata, (i % 3) + 1, n);
      check("issue_latency", DW'(n), DW'(1));
      check_done(vt[i].port, vt[i].exp_dout, "vec");
    end

    // Command while busy is dropped
    load(1, 1'b1, 1'b0, 25'h0000AAA, {4{32'hCAFEF00D}}, 16'h00FF, 4'h2);
    push(1'b1, 25'h0000AAA, {4{32'hCAFEF00D}}, 16'h00FF, 4'h2);
    pulse();
    @(negedge clk);
    check("busy_held", DW'(bus.req_busy[1]), DW'(1));
    load(1, 1'b0, 1'b1, 25'h0000BBB, {4{32'h12345678}}, 16'hAAAA, 4'h3);
    pulse();
    n0 = cmd_seen;
    serve({16{8'h66}}, 2, n);
    check_done(1, {16{8'h5A}}, "busy_drop");
    repeat (8) @(negedge clk);
    check("busy_drop_cmds", DW'(cmd_seen - n0), DW'(1));
    check("busy_drop_idle", DW'(bus.req_busy), '0);

    // Reset while waiting on the controller
    load(0, 1'b0, 1'b1, 25'h0000777, {16{8'h3C}}, 16'hF0F0, 4'h8);
    push(1'b0, 25'h0000777, {16{8'h3C}}, 16'hF0F0, 4'h8);
    pulse();
    wait_cmd(n);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_mid_wait");
    @(posedge clk); #1 rst = 1'b0;
    do_ack({16{8'h99}});
    acc = '0;
    repeat (4) begin
      @(negedge clk);
      acc |= bus.req_ack;
    end
    check("rst_ack_ignored", DW'(acc), '0);
    check("rst_dout_zero", bus.req_dout, '0);

    // Four-way contention; port 0 re-requests in its DONE cycle
    for (int p = 0; p < 4; p++) begin
      load(p, 1'b1, 1'b0, 25'h0100000 + AW'(p), {4{32'h11110000 + p}}, 16'hFFFF, 4'h4);
      push(1'b1, 25'h0100000 + AW'(p), {4{32'h11110000 + p}}, 16'hFFFF, 4'h4);
    end
    pulse();
    serve('0, 1, n);
    load(0, 1'b1, 1'b0, 25'h0100010, {4{32'h0000BEAD}}, 16'h0F0F, 4'h1);
    c0b.wr = 1'b1; c0b.adrs = 25'h0100010; c0b.din = {4{32'h0000BEAD}};
    c0b.en = 16'h0F0F; c0b.burst = 4'h1;
`ifdef SDRAM_ARB_PRIO0_EN
    exp_q.push_front(c0b);
    ord = '{0, 1, 2, 3};
`else
    exp_q.push_back(c0b);
    ord = '{1, 2, 3, 0};
`endif
    check_done(0, '0, "rr_first");
    for (int k = 0; k < 4; k++) begin
      serve('0, 1, n);
      check_done(ord[k], '0, "rr_order");
    end

    // Port 0 arrives while port 1 waits on the controller, port 2 already pending
    do_reset();
    load(1, 1'b1, 1'b0, 25'h0200001, {4{32'h00000001}}, 16'h0001, 4'h1);
    load(2, 1'b1, 1'b0, 25'h0200002, {4{32'h00000002}}, 16'h0002, 4'h2);
    push(1'b1, 25'h0200001, {4{32'h00000001}}, 16'h0001, 4'h1);
    pulse();
    wait_cmd(n);
    @(posedge clk); #1;
    load(0, 1'b1, 1'b0, 25'h0200000, {4{32'h00000000}}, 16'h0004, 4'h3);
`ifdef SDRAM_ARB_PRIO0_EN
    push(1'b1, 25'h0200000, {4{32'h00000000}}, 16'h0004, 4'h3);
    push(1'b1, 25'h0200002, {4{32'h00000002}}, 16'h0002, 4'h2);
    ord = '{0, 2, 0, 0};
`else
    push(1'b1, 25'h0200002, {4{32'h00000002}}, 16'h0002, 4'h2);
    push(1'b1, 25'h0200000, {4{32'h00000000}}, 16'h0004, 4'h3);
    ord = '{2, 0, 0, 0};
`endif
    pulse();
    do_ack('0);
    check_done(1, '0, "late_first");
    for (int k = 0; k < 2; k++) begin
      serve('0, 1, n);
      check_done(ord[k], '0, "late_order");
    end

    repeat (4) @(negedge clk);
    check("sb_empty", DW'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
